cdc_handshake_sender: RTL

Source-domain controller for a four-phase request/acknowledge clock-domain crossing. It accepts a word on a valid/ready interface, holds it stable on the crossing bus and raises a request. It waits for the far side's acknowledge, brought into this domain through an internal flip-flop synchronizer, then completes the return-to-zero phase before accepting the next word. It sits beside the synchronizer library as the sequencer that drives it.

---
 rtl/cdc_handshake_sender.sv | 103 ++++++++++
 1 files changed

// File: rtl/cdc_handshake_sender.sv
// Four-phase req/ack CDC source sequencer: cdc_request rises the cycle after a write is accepted; cdc_data stays stable until the next accepted write.
// Backpressure: write_ready stays low from acceptance until the synchronized acknowledge has risen and then fallen again.
module cdc_handshake_sender #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_valid,
  output logic             write_ready,
  output logic [WIDTH-1:0] cdc_data,
  output logic             cdc_request,
  input  logic             cdc_acknowledge,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [STAGES-1:0] ack_sync_q, ack_sync_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              request_q, request_d;
  logic              busy_q, busy_d;
  logic              acknowledge_synced;
  logic              accept;

  // The raw acknowledge only ever enters the first synchronizer flop.
  if (STAGES > 1) begin : g_sync_chain
    always_comb begin
      ack_sync_d = {ack_sync_q[STAGES-2:0], cdc_acknowledge};
    end
  end else begin : g_sync_single
    always_comb begin
      ack_sync_d = cdc_acknowledge;
    end
  end

  assign acknowledge_synced = ack_sync_q[STAGES-1];

  assign write_ready = (state_q == IDLE) && !reset && !acknowledge_synced;
  assign accept      = write_valid && write_ready;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    request_d = request_q;
    unique case (state_q)
      IDLE: begin
        request_d = 1'b0;
        if (accept) begin
          data_d    = write_data;
          request_d = 1'b1;
          state_d   = REQUEST;
        end
      end
      REQUEST: begin
        request_d = 1'b1;
        if (acknowledge_synced) begin
          request_d = 1'b0;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        // Wait for the far side to return to zero before the next word.
        request_d = 1'b0;
        if (!acknowledge_synced) begin
          state_d = IDLE;
        end
      end
      default: begin
        request_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ack_sync_q <= '0;
      data_q     <= '0;
      request_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_sync_q <= ack_sync_d;
      data_q     <= data_d;
      request_q  <= request_d;
      busy_q     <= busy_d;
    end
  end

  assign cdc_data    = data_q;
  assign cdc_request = request_q;
  assign busy        = busy_q;

endmodule
